quantizer_multichannel: RTL and testbench

//  Per-channel symmetric requantizer (INT32 accumulator -> INT<OUT_W>) for the accelerator output path.
//  On start_calib it captures one max_abs per channel and computes each channel's Q(FRAC_W) reciprocal

---
 rtl/quantizer_multichannel.sv | 225 ++++++++++++++++++++++
 tb/tb_quantizer_multichannel.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/quantizer_multichannel.sv
// Per-channel symmetric requantizer: serial restoring divider computes Q(FRAC_W) scales, then a
// 3-stage multiply/round/saturate pipeline. Define QUANT_SAT_CNT_EN to add the sat_count output.
module quantizer_multichannel #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int NUM_CH  = 4,
  parameter int SCALE_W = 32,
  parameter int FRAC_W  = 24,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start_calib,
  input  logic [NUM_CH*IN_W-1:0]    max_abs,
  input  logic [IN_W-1:0]           data_in,
  input  logic [CH_W-1:0]           data_ch,
  input  logic                      data_valid,
  output logic [OUT_W-1:0]          data_out,
  output logic [CH_W-1:0]           data_ch_out,
  output logic                      data_valid_out,
  output logic                      calib_busy,
  output logic                      calib_ready,
  output logic                      data_ready,
  output logic [NUM_CH*SCALE_W-1:0] scale_dbg
`ifdef QUANT_SAT_CNT_EN
  ,
  output logic [15:0]               sat_count
`endif
);

  localparam int PW     = IN_W + SCALE_W + 1;
  localparam int STEP_W = $clog2(SCALE_W + 1);
  localparam int TAB_N  = 1 << CH_W;
  localparam logic [SCALE_W-1:0] DIVIDEND = SCALE_W'(2**(OUT_W-1) - 1) << FRAC_W;
  localparam logic [PW-1:0] RND_POS = PW'(1) << (FRAC_W - 1);
  localparam logic [PW-1:0] RND_NEG = RND_POS - PW'(1);
  localparam logic signed [PW-1:0] QMAX = PW'(2**(OUT_W-1) - 1);
  localparam logic signed [PW-1:0] QMIN = -QMAX;

  typedef enum logic [1:0] {ST_IDLE, ST_CALIB, ST_READY} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_ready;
  logic [CH_W-1:0]     r_cal_ch;
  logic [STEP_W-1:0]   r_step;
  logic [IN_W-1:0]     r_rem;
  logic [SCALE_W-1:0]  r_quo;
  logic [IN_W-1:0]     r_max_abs [NUM_CH];
  logic [SCALE_W-1:0]  r_shadow  [NUM_CH];
  logic [SCALE_W-1:0]  r_scale   [NUM_CH];

  logic [IN_W-1:0]     w_divisor;
  logic [IN_W:0]       w_shift;
  logic                w_ge;
  logic [IN_W-1:0]     w_sub;
  logic [IN_W-1:0]     w_rem_next;
  logic [SCALE_W-1:0]  w_quo_next;
  logic [SCALE_W-1:0]  w_result;
  logic                w_last_step;
  logic                w_last_ch;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_divisor   = r_max_abs[r_cal_ch];
  assign w_shift     = {r_rem, r_quo[SCALE_W-1]};
  assign w_ge        = w_shift >= {1'b0, w_divisor};
  assign w_sub       = w_shift[IN_W-1:0] - w_divisor;
  assign w_rem_next  = w_ge ? w_sub : w_shift[IN_W-1:0];
  assign w_quo_next  = {r_quo[SCALE_W-2:0], w_ge};
  assign w_result    = (w_divisor == '0) ? '0 : w_quo_next;
  assign w_last_step = r_step == STEP_W'(SCALE_W);
  assign w_last_ch   = r_cal_ch == CH_W'(NUM_CH - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_cal_ch <= '0;
      r_step   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_max_abs[c] <= '0;
        r_shadow[c]  <= '0;
        r_scale[c]   <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_READY: begin
          if (start_calib) begin
            r_state  <= ST_CALIB;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            r_cal_ch <= '0;
            r_step   <= '0;
            for (int c = 0; c < NUM_CH; c++)
              r_max_abs[c] <= max_abs[c*IN_W +: IN_W];
          end
        end
        ST_CALIB: begin
          if (r_step == '0) begin
            r_rem  <= '0;
            r_quo  <= DIVIDEND;
            r_step <= STEP_W'(1);
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (w_last_step) begin
              r_step             <= '0;
              r_shadow[r_cal_ch] <= w_result;
              if (w_last_ch) begin
                // The final channel's result bypasses the shadow so all scales commit together.
                r_state <= ST_READY;
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
                for (int c = 0; c < NUM_CH; c++)
                  r_scale[c] <= (c == NUM_CH - 1) ? w_result : r_shadow[c];
              end else begin
                r_cal_ch <= r_cal_ch + 1'b1;
              end
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign calib_busy  = r_busy;
  assign calib_ready = r_ready;
  assign data_ready  = r_ready;

  // Tag space padded to a power of two; unmapped channels read scale 0.
  logic [SCALE_W-1:0] w_scale_tab [TAB_N];
  genvar gi;
  generate
    for (gi = 0; gi < TAB_N; gi++) begin : g_tab
      if (gi < NUM_CH) begin : g_map
        assign w_scale_tab[gi] = r_scale[gi];
      end else begin : g_unmap
        assign w_scale_tab[gi] = '0;
      end
    end
    for (gi = 0; gi < NUM_CH; gi++) begin : g_dbg
      assign scale_dbg[gi*SCALE_W +: SCALE_W] = r_scale[gi];
    end
  endgenerate

  logic signed [PW-1:0] w_a;
  logic signed [PW-1:0] w_b;
  logic signed [PW-1:0] w_prod;
  logic [PW-1:0]        w_sum;
  logic                 w_hi;
  logic                 w_lo;
  logic [OUT_W-1:0]     w_sat_val;

  logic                 r_s1_v;
  logic [CH_W-1:0]      r_s1_ch;
  logic [PW-1:0]        r_s1_prod;
  logic                 r_s2_v;
  logic [CH_W-1:0]      r_s2_ch;
  logic signed [PW-1:0] r_s2_val;
  logic                 r_out_v;
  logic [CH_W-1:0]      r_out_ch;
  logic [OUT_W-1:0]     r_out;

  assign w_a    = {{(SCALE_W+1){data_in[IN_W-1]}}, data_in};
  assign w_b    = {{IN_W{1'b0}}, 1'b0, w_scale_tab[data_ch]};
  assign w_prod = w_a * w_b;
  // Bias one less for negatives so the floor shift rounds half away from zero.
  assign w_sum  = r_s1_prod + (r_s1_prod[PW-1] ? RND_NEG : RND_POS);
  assign w_hi   = r_s2_val > QMAX;
  assign w_lo   = r_s2_val < QMIN;
  assign w_sat_val = w_hi ? QMAX[OUT_W-1:0] : (w_lo ? QMIN[OUT_W-1:0] : r_s2_val[OUT_W-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_v    <= 1'b0;
      r_s1_ch   <= '0;
      r_s1_prod <= '0;
      r_s2_v    <= 1'b0;
      r_s2_ch   <= '0;
      r_s2_val  <= '0;
      r_out_v   <= 1'b0;
      r_out_ch  <= '0;
      r_out     <= '0;
    end else begin
      r_s1_v    <= data_valid;
      r_s1_ch   <= data_ch;
      r_s1_prod <= w_prod;
      r_s2_v    <= r_s1_v;
      r_s2_ch   <= r_s1_ch;
      r_s2_val  <= $signed(w_sum) >>> FRAC_W;
      r_out_v   <= r_s2_v;
      r_out_ch  <= r_s2_ch;
      r_out     <= w_sat_val;
    end
  end

  assign data_out       = r_out;
  assign data_ch_out    = r_out_ch;
  assign data_valid_out = r_out_v;

`ifdef QUANT_SAT_CNT_EN
  logic        w_cal_start;
  logic [15:0] r_sat_cnt;

  assign w_cal_start = start_calib && (r_state != ST_CALIB);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_sat_cnt <= '0;
    else if (w_cal_start)
      r_sat_cnt <= '0;
    else if (r_s2_v && (w_hi || w_lo) && (r_sat_cnt != 16'hFFFF))
      r_sat_cnt <= r_sat_cnt + 16'd1;
  end

  assign sat_count = r_sat_cnt;
`endif

endmodule

// File: tb/tb_quantizer_multichannel.sv
// Directed bench for quantizer_multichannel: a 4-channel DUT plus a 3-channel DUT that exposes
// an unmapped channel tag. Both share stimulus.
module tb_quantizer_multichannel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start_calib;
  logic [127:0] max_abs;
  logic [31:0]  data_in;
  logic [1:0]   data_ch;
  logic         data_valid;

  logic [7:0]   d4_out, d3_out;
  logic [1:0]   d4_ch, d3_ch;
  logic         d4_v, d3_v, d4_busy, d3_busy, d4_ready, d3_ready, d4_dready, d3_dready;
  logic [127:0] d4_scale;
  logic [95:0]  d3_scale;
`ifdef QUANT_SAT_CNT_EN
  logic [15:0]  d4_sat, d3_sat;
`endif

  quantizer_multichannel #(.NUM_CH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start_calib(start_calib), .max_abs(max_abs),
    .data_in(data_in), .data_ch(data_ch), .data_valid(data_valid),
    .data_out(d4_out), .data_ch_out(d4_ch), .data_valid_out(d4_v),
    .calib_busy(d4_busy), .calib_ready(d4_ready), .data_ready(d4_dready),
    .scale_dbg(d4_scale)
`ifdef QUANT_SAT_CNT_EN
    , .sat_count(d4_sat)
`endif
  );

  quantizer_multichannel #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start_calib(start_calib), .max_abs(max_abs[95:0]),
    .data_in(data_in), .data_ch(data_ch), .data_valid(data_valid),
    .data_out(d3_out), .data_ch_out(d3_ch), .data_valid_out(d3_v),
    .calib_busy(d3_busy), .calib_ready(d3_ready), .data_ready(d3_dready),
    .scale_dbg(d3_scale)
`ifdef QUANT_SAT_CNT_EN
    , .sat_count(d3_sat)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;
  int busy_total = 0;
  int b0;

  always @(posedge clk) if (d4_busy) busy_total++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start_calib = 1'b1;
    @(negedge clk); start_calib = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!d4_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", d4_ready, 1);
  endtask

  // One isolated sample; dut3 has no channel 3 so it must output 0 there.
  task automatic one(input string tag, input logic [1:0] ch, input int d, input int exp);
    int exp3;
    exp3 = (ch == 2'd3) ? 0 : exp;
    @(negedge clk); data_valid = 1'b1; data_in = d; data_ch = ch;
    @(negedge clk); data_valid = 1'b0;
    @(negedge clk); check({tag, "_early"}, d4_v, 0);
    @(negedge clk);
    check({tag, "_v"}, d4_v, 1);
    check({tag, "_out"}, $signed(d4_out), exp);
    check({tag, "_tag"}, d4_ch, ch);
    check({tag, "_out3"}, $signed(d3_out), exp3);
    check({tag, "_tag3"}, d3_ch, ch);
    $display("sample %s ch=%0d in=%0d out=%0d out3=%0d", tag, ch, d, $signed(d4_out), $signed(d3_out));
  endtask

  function automatic int model(input int ch, input int d);
    int v;
    case (ch)
      0, 3:    v = d;
      1:       v = (d >= 0) ? (d + 1) / 2 : -((-d + 1) / 2);
      default: v = 0;
    endcase
    if (v > 127) v = 127;
    if (v < -127) v = -127;
    return v;
  endfunction

  int exp_sc[4];

  initial begin
    reset_n = 1'b0; start_calib = 1'b0; max_abs = '0;
    data_in = '0; data_ch = '0; data_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", d4_busy, 0);
    check("rst_ready", d4_ready, 0);
    check("rst_valid", d4_v, 0);
    check("rst_out", d4_out, 0);
    check("rst_scale", d4_scale[63:0] | d4_scale[127:64], 0);
`ifdef QUANT_SAT_CNT_EN
    check("rst_sat", d4_sat, 0);
`endif

    // T1: all channels 127 -> scale 2^24
    max_abs = {32'd127, 32'd127, 32'd127, 32'd127};
    b0 = busy_total;
    pulse_start();
    check("t1_busy_on", d4_busy, 1);
    wait_ready(400);
    check("t1_busy_len", busy_total - b0, 132);
    check("t1_busy_off", d4_busy, 0);
    check("t1_dready", d4_dready, 1);
    check("t1_ready3", d3_ready, 1);
    for (int c = 0; c < 4; c++)
      check($sformatf("t1_scale%0d", c), d4_scale[c*32 +: 32], 16777216);
    one("t1_50", 2'd0, 50, 50);

    // T3: saturation on ch0
    one("t3_p1000", 2'd0, 1000, 127);
    one("t3_m1000", 2'd0, -1000, -127);
    one("t3_m128", 2'd0, -128, -127);
    one("t3_m127", 2'd0, -127, -127);
`ifdef QUANT_SAT_CNT_EN
    check("t3_sat", d4_sat, 3);
`endif

    // Recalibrate: ch1 254, ch2 0; old scales hold until commit, mid-CALIB start ignored
    max_abs = {32'd127, 32'd0, 32'd254, 32'd127};
    b0 = busy_total;
    pulse_start();
    check("rc_ready_low", d4_ready, 0);
    check("rc_busy", d4_busy, 1);
`ifdef QUANT_SAT_CNT_EN
    check("rc_sat_clr", d4_sat, 0);
`endif
    one("rc_old", 2'd1, 3, 3);
    pulse_start();
    wait_ready(400);
    check("rc_busy_len", busy_total - b0, 132);
    exp_sc = '{16777216, 8388608, 0, 16777216};
    for (int c = 0; c < 4; c++)
      check($sformatf("rc_scale%0d", c), d4_scale[c*32 +: 32], exp_sc[c]);

    // T2: half away from zero on ch1
    one("t2_p3", 2'd1, 3, 2);
    one("t2_m3", 2'd1, -3, -2);
    one("t2_p1", 2'd1, 1, 1);
    one("t2_m1", 2'd1, -1, -1);

    // T4: zero scale and unmapped channel
    one("t4_ch2", 2'd2, 12345, 0);
    one("t4_ch3", 2'd3, 20, 20);

    // T5: 20 back-to-back samples, rotating channels
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i >= 3 && i < 23) begin
        check($sformatf("t5_v%0d", i - 3), d4_v, 1);
        check($sformatf("t5_out%0d", i - 3), $signed(d4_out), model((i - 3) % 4, (i - 3) * 13 - 100));
        check($sformatf("t5_tag%0d", i - 3), d4_ch, (i - 3) % 4);
        $display("stream k=%0d ch=%0d out=%0d", i - 3, d4_ch, $signed(d4_out));
      end
      if (i == 23) check("t5_tail", d4_v, 0);
      if (i < 20) begin
        data_valid = 1'b1; data_in = i * 13 - 100; data_ch = 2'(i % 4);
      end else begin
        data_valid = 1'b0;
      end
    end

    // T6: reset during calibration
    pulse_start();
    repeat (38) @(negedge clk);
    check("t6_mid_busy", d4_busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_busy", d4_busy, 0);
    check("t6_ready", d4_ready, 0);
    check("t6_scale", d4_scale[63:0] | d4_scale[127:64], 0);
    check("t6_out", d4_out, 0);
    check("t6_valid", d4_v, 0);
`ifdef QUANT_SAT_CNT_EN
    check("t6_sat", d4_sat, 0);
`endif
    reset_n = 1'b1;
    b0 = busy_total;
    pulse_start();
    wait_ready(400);
    check("t6_busy_len", busy_total - b0, 132);
    check("t6_scale1", d4_scale[63:32], 8388608);
    one("t6_post", 2'd1, -3, -2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
